rename_free_list: RTL



---
 rtl/rename_free_list_pkg.sv | 23 ++
 rtl/rename_free_list_slot_compact.sv | 28 ++
 rtl/rename_free_list.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/rename_free_list_pkg.sv
// -----------------------------------------------------------------------------
// rename_free_list_pkg
// Shared definitions for the 4-wide rename free list: physical/architectural
// register counts, tag and pointer types, and a 4-bit popcount helper.
// -----------------------------------------------------------------------------
package rename_free_list_pkg;

  localparam int PHY_W    = 6;          // physical tag width
  localparam int NUM_PHY  = 64;         // physical registers == FIFO depth
  localparam int NUM_ARCH = 32;         // tags mapped at reset (not free)
  localparam int PTR_W    = PHY_W + 1;  // pointer carries an extra wrap bit
  localparam int SLOTS    = 4;          // rename / commit width

  typedef logic [PHY_W-1:0] phy_tag_t;
  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [2:0]       cnt4_t;     // 0..4
  typedef logic [1:0]       slot_off_t; // prefix offset 0..3

  function automatic cnt4_t popcount4(input logic [SLOTS-1:0] v);
    return cnt4_t'(v[0]) + cnt4_t'(v[1]) + cnt4_t'(v[2]) + cnt4_t'(v[3]);
  endfunction

endpackage

// File: rtl/rename_free_list_slot_compact.sv
// -----------------------------------------------------------------------------
// slot_compact
// For a 4-bit request mask, gives each slot the number of set bits below it.
// Used to pack sparse slot requests onto consecutive FIFO entries.
//   mask_i   in  4      per-slot request
//   offset_o out 4 x 2  count of requesting slots strictly before slot i
// -----------------------------------------------------------------------------
module slot_compact
  import rename_free_list_pkg::*;
(
  input  logic      [SLOTS-1:0] mask_i,
  output slot_off_t [SLOTS-1:0] offset_o
);

  slot_off_t acc;

  // NOTE: every variable written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    acc      = '0;
    offset_o = '0;
    for (int i = 0; i < SLOTS; i++) begin
      offset_o[i] = acc;
      acc         = acc + slot_off_t'(mask_i[i]);
    end
  end

endmodule

// File: rtl/rename_free_list.sv
// -----------------------------------------------------------------------------
// rename_free_list
// Physical-register free list for the 4-wide rename stage. A circular FIFO of
// free tags: rename groups pop 0..4 tags at once (all-or-nothing), commit
// pushes 0..4 released tags per cycle. Tags are returned combinationally in the
// same cycle the group fires.
//
// Ports
//   clk, rst_n                     clock, synchronous active-low reset
//   alloc_valid                    rename group present
//   alloc_req[3:0]                 bit i-1 set: Inst i needs a tag
//   alloc_ready                    enough free tags for the whole group
//   Inst1_Phy..Inst4_Phy           allocated tag per slot, 0 if not requesting
//   free_valid[3:0]                bit i set: free_phy<i> is valid
//   free_phy0..free_phy3           tags released by commit
//   free_count[6:0]                number of free tags (registered)
//   flush, commit_alloc[2:0]       only with FREELIST_FLUSH_EN: restore head
//                                  to the committed allocation point
//
// Build option: define FREELIST_FLUSH_EN to add the flush recovery path.
// -----------------------------------------------------------------------------
module rename_free_list
  import rename_free_list_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alloc_valid,
  input  logic [SLOTS-1:0] alloc_req,
  output logic             alloc_ready,
  output logic [PHY_W-1:0] Inst1_Phy,
  output logic [PHY_W-1:0] Inst2_Phy,
  output logic [PHY_W-1:0] Inst3_Phy,
  output logic [PHY_W-1:0] Inst4_Phy,
  input  logic [SLOTS-1:0] free_valid,
  input  logic [PHY_W-1:0] free_phy0,
  input  logic [PHY_W-1:0] free_phy1,
  input  logic [PHY_W-1:0] free_phy2,
  input  logic [PHY_W-1:0] free_phy3,
  output logic [PTR_W-1:0] free_count
`ifdef FREELIST_FLUSH_EN
  ,
  input  logic             flush,
  input  logic [2:0]       commit_alloc
`endif
);

  phy_tag_t              mem_q [NUM_PHY];
  ptr_t                  head_q, head_d;
  ptr_t                  tail_q, tail_d;
  ptr_t                  count;
  slot_off_t [SLOTS-1:0] alloc_off;
  slot_off_t [SLOTS-1:0] free_off;
  phy_tag_t              alloc_tag [SLOTS];
  phy_tag_t              free_tag  [SLOTS];
  phy_tag_t              rd_idx    [SLOTS];
  phy_tag_t              wr_idx    [SLOTS];
  logic      [SLOTS-1:0] free_zero;
  cnt4_t                 n_req, n_free;
  logic                  fire;
  logic                  flush_act;
  logic      [PTR_W:0]   count_next_ext;

  slot_compact u_alloc_compact (.mask_i(alloc_req),  .offset_o(alloc_off));
  slot_compact u_free_compact  (.mask_i(free_valid), .offset_o(free_off));

  assign free_tag[0] = free_phy0;
  assign free_tag[1] = free_phy1;
  assign free_tag[2] = free_phy2;
  assign free_tag[3] = free_phy3;

  // Pointer difference stays correct across wrap thanks to the extra MSB.
  assign count      = tail_q - head_q;
  assign free_count = count;
  assign n_req      = popcount4(alloc_req);
  assign n_free     = popcount4(free_valid);

`ifdef FREELIST_FLUSH_EN
  ptr_t arch_head_q, arch_head_d;

  assign flush_act   = flush;
  // The commit of the flush cycle itself is folded into the restore point.
  assign arch_head_d = arch_head_q + ptr_t'(commit_alloc);

  always_ff @(posedge clk) begin
    if (!rst_n) arch_head_q <= '0;
    else        arch_head_q <= arch_head_d;
  end
`else
  assign flush_act = 1'b0;
`endif

  // Readiness uses the registered count only; same-cycle frees are not
  // bypassed, which keeps the free path off the rename critical path.
  assign alloc_ready = (count >= ptr_t'(n_req)) && !flush_act;
  assign fire        = alloc_valid && alloc_ready;

  always_comb begin
    for (int i = 0; i < SLOTS; i++) begin
      rd_idx[i]    = head_q[PHY_W-1:0] + phy_tag_t'(alloc_off[i]);
      wr_idx[i]    = tail_q[PHY_W-1:0] + phy_tag_t'(free_off[i]);
      alloc_tag[i] = alloc_req[i] ? mem_q[rd_idx[i]] : '0;
      free_zero[i] = free_valid[i] && (free_tag[i] == '0);
    end
  end

  assign Inst1_Phy = alloc_tag[0];
  assign Inst2_Phy = alloc_tag[1];
  assign Inst3_Phy = alloc_tag[2];
  assign Inst4_Phy = alloc_tag[3];

  always_comb begin
    head_d = head_q;
    if (fire) head_d = head_q + ptr_t'(n_req);
`ifdef FREELIST_FLUSH_EN
    if (flush) head_d = arch_head_d;
`endif
    tail_d = tail_q + ptr_t'(n_free);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head_q <= '0;
      tail_q <= ptr_t'(NUM_ARCH);
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
    end
  end

  // NOTE: only the first NUM_ARCH entries are loaded at reset (with the
  // initially free tags); the rest are written before they can be read, so
  // they carry no reset and stay plain storage.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ARCH; i++) mem_q[i] <= phy_tag_t'(NUM_ARCH + i);
    end else begin
      for (int j = 0; j < SLOTS; j++) begin
        if (free_valid[j]) mem_q[wr_idx[j]] <= free_tag[j];
      end
    end
  end

  // Illegal usage checks (simulation only; no recovery in hardware).
  assign count_next_ext = (PTR_W+1)'(count) + (PTR_W+1)'(n_free)
                        - (fire ? (PTR_W+1)'(n_req) : (PTR_W+1)'(0));

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !flush_act |-> (count_next_ext <= (PTR_W+1)'(NUM_PHY)));

  a_no_free_tag0: assert property (@(posedge clk) disable iff (!rst_n)
    free_zero == '0);

  a_req_known: assert property (@(posedge clk) disable iff (!rst_n)
    alloc_valid |-> !$isunknown(alloc_req));

endmodule
